// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan controller.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_e;

  // Digit i is dark under leading-zero blanking when it and every more
  // significant digit are zero; digit 0 always stays visible.
  function automatic logic lz_blank(input logic [15:0] val,
                                    input logic [1:0]  idx,
                                    input logic        lzb_en);
    logic all_zero;
    all_zero = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (d >= int'(idx) && val[4*d +: 4] != 4'h0) all_zero = 1'b0;
    end
    return lzb_en && (idx != 2'd0) && all_zero;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Load/control inputs and scan outputs of the seven-segment controller.
interface seg7_scan_if;
  import seg7_pkg::*;

  logic                  LOAD;
  logic [15:0]           DIN;
  logic [NUM_DIGITS-1:0] DPIN;
  logic [NUM_DIGITS-1:0] EN_MASK;
  logic                  LZB;
  logic [NUM_DIGITS-1:0] AN;
  logic [3:0]            NIBBLE;
  logic                  DP;
  logic                  PEND;
  logic                  FRAME;

  modport master (
    output LOAD, DIN, DPIN, EN_MASK, LZB,
    input  AN, NIBBLE, DP, PEND, FRAME
  );

  modport slave (
    input  LOAD, DIN, DPIN, EN_MASK, LZB,
    output AN, NIBBLE, DP, PEND, FRAME
  );
endinterface

// File: rtl/seg7_scan_ctrl_tick_gen.sv
// Free-running prescaler producing a one-cycle scan tick every DIV cycles.
module scan_tick_gen #(
  parameter logic [31:0] DIV = 32'd50000
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);

  logic [31:0] cnt_q, cnt_d;

  // Count 0..DIV-1 and wrap.
  always_comb begin
    cnt_d = (cnt_q == DIV - 32'd1) ? 32'd0 : cnt_q + 32'd1;
  end

  // Prescaler register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= 32'd0;
    else     cnt_q <= cnt_d;
  end

  assign TICK = (cnt_q == DIV - 32'd1);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed display scanner with dead-time between digits,
// double-buffered display value committed only at frame boundaries, and
// optional leading-zero blanking. Outputs are registered from next-state
// values so they line up with the internal scan state.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter logic [31:0] DIV       = 32'd50000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic       CLK,
  input  logic       RST,
  seg7_scan_if.slave bus
);

  logic tick;

  scan_tick_gen #(.DIV(DIV)) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (tick)
  );

  scan_state_e     state_q, state_d;
  logic [3:0]      dead_q, dead_d;
  logic [1:0]      idx_q, idx_d;
  logic            frame_q, frame_d;
  logic [15:0]     disp_q, disp_d;
  logic [15:0]     pbuf_q, pbuf_d;
  logic [3:0]      ddp_q, ddp_d;
  logic [3:0]      pdp_q, pdp_d;
  logic            pend_q, pend_d;
  logic [3:0]      an_q, an_d;
  logic [3:0]      nib_q, nib_d;
  logic            dp_q, dp_d;
  logic            lit;

  // Scan sequencing: dead-time in S_BLANK, hold digit in S_DRIVE until tick.
  always_comb begin
    state_d = state_q;
    dead_d  = dead_q;
    idx_d   = idx_q;
    frame_d = 1'b0;
    case (state_q)
      S_BLANK: begin
        dead_d = dead_q + 4'd1;
        if (dead_q == 4'(BLANK_CYC)) state_d = S_DRIVE;
      end
      S_DRIVE: begin
        if (tick) begin
          state_d = S_BLANK;
          dead_d  = 4'd0;
          idx_d   = idx_q + 2'd1;
          frame_d = (idx_q == 2'd3);
        end
      end
      default: state_d = S_BLANK;
    endcase
  end

  // Double buffer: loads park in the pending buffer except in the frame
  // cycle, where the display register takes either a coincident load or
  // the pending value.
  always_comb begin
    disp_d = disp_q;
    ddp_d  = ddp_q;
    pbuf_d = pbuf_q;
    pdp_d  = pdp_q;
    pend_d = pend_q;
    if (frame_q) begin
      if (bus.LOAD) begin
        disp_d = bus.DIN;
        ddp_d  = bus.DPIN;
        pend_d = 1'b0;
      end else if (pend_q) begin
        disp_d = pbuf_q;
        ddp_d  = pdp_q;
        pend_d = 1'b0;
      end
    end else if (bus.LOAD) begin
      pbuf_d = bus.DIN;
      pdp_d  = bus.DPIN;
      pend_d = 1'b1;
    end
  end

  // Output image for the next cycle, derived from next-state values.
  always_comb begin
    lit   = (state_d == S_DRIVE) && bus.EN_MASK[idx_d] &&
            !lz_blank(disp_d, idx_d, bus.LZB);
    an_d  = lit ? ~(4'b0001 << idx_d) : AN_OFF;
    nib_d = disp_d[{idx_d, 2'b00} +: 4];
    dp_d  = lit & ddp_d[idx_d];
  end

  // State, buffers and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_BLANK;
      dead_q  <= 4'd0;
      idx_q   <= 2'd0;
      frame_q <= 1'b0;
      disp_q  <= 16'h0;
      ddp_q   <= 4'h0;
      pbuf_q  <= 16'h0;
      pdp_q   <= 4'h0;
      pend_q  <= 1'b0;
      an_q    <= AN_OFF;
      nib_q   <= 4'h0;
      dp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dead_q  <= dead_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      disp_q  <= disp_d;
      ddp_q   <= ddp_d;
      pbuf_q  <= pbuf_d;
      pdp_q   <= pdp_d;
      pend_q  <= pend_d;
      an_q    <= an_d;
      nib_q   <= nib_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.AN     = an_q;
  assign bus.NIBBLE = nib_q;
  assign bus.DP     = dp_q;
  assign bus.PEND   = pend_q;
  assign bus.FRAME  = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with DIV = 8, BLANK_CYC = 2.
module tb_seg7_scan_ctrl;
  import seg7_pkg::*;

  localparam int DIV_I     = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME_LEN = 4 * DIV_I;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  seg7_scan_if bus ();

  seg7_scan_ctrl #(
    .DIV       (32'(DIV_I)),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cycles since reset release plus the buffered values.
  int          k;
  logic [15:0] m_disp, m_pbuf;
  logic [3:0]  m_ddp, m_pdp;
  logic        m_pend;
  logic [3:0]  m_en_prev;
  logic        m_lzb_prev;

  task automatic chk4(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s k=%0d got=%b exp=%b", tag, k, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s k=%0d got=%b exp=%b", tag, k, got, exp);
    end
  endtask

  function automatic logic model_frame();
    return (k > 0) && (k % FRAME_LEN == 0);
  endfunction

  task automatic model_reset();
    k          = 0;
    m_disp     = 16'h0;
    m_pbuf     = 16'h0;
    m_ddp      = 4'h0;
    m_pdp      = 4'h0;
    m_pend     = 1'b0;
    m_en_prev  = bus.EN_MASK;
    m_lzb_prev = bus.LZB;
  endtask

  task automatic check_outputs(input string tag);
    int         cnt, idx;
    logic       drive, blank, lit;
    logic [3:0] e_an, e_nib;
    cnt   = k % DIV_I;
    idx   = (k / DIV_I) % 4;
    drive = (cnt > BLANK_CYC);
    blank = m_lzb_prev && (idx > 0) && ((m_disp >> (4 * idx)) == 16'h0);
    lit   = drive && m_en_prev[idx] && !blank;
    e_an  = lit ? ~(4'b0001 << idx) : 4'hF;
    e_nib = 4'((m_disp >> (4 * idx)) & 16'hF);
    chk4({tag, ".AN"}, bus.AN, e_an);
    chk4({tag, ".NIBBLE"}, bus.NIBBLE, e_nib);
    chk1({tag, ".DP"}, bus.DP, lit && m_ddp[idx]);
    chk1({tag, ".PEND"}, bus.PEND, m_pend);
    chk1({tag, ".FRAME"}, bus.FRAME, model_frame());
  endtask

  // One clock cycle: check, drive inputs, advance model, move to next negedge.
  task automatic cyc(input logic load, input logic [15:0] din,
                     input logic [3:0] dpin, input string tag);
    check_outputs(tag);
    bus.LOAD = load;
    bus.DIN  = din;
    bus.DPIN = dpin;
    if (model_frame()) begin
      if (load) begin
        m_disp = din;
        m_ddp  = dpin;
        m_pend = 1'b0;
      end else if (m_pend) begin
        m_disp = m_pbuf;
        m_ddp  = m_pdp;
        m_pend = 1'b0;
      end
    end else if (load) begin
      m_pbuf = din;
      m_pdp  = dpin;
      m_pend = 1'b1;
    end
    m_en_prev  = bus.EN_MASK;
    m_lzb_prev = bus.LZB;
    k++;
    @(negedge CLK);
    bus.LOAD = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'($urandom), 4'($urandom), tag);
  endtask

  // Advance to a given position within the frame (0 = frame cycle).
  task automatic to_phase(input int ph, input string tag);
    int guard;
    guard = 0;
    while (((k % FRAME_LEN) != ph || k == 0) && guard < 2 * FRAME_LEN) begin
      cyc(1'b0, 16'($urandom), 4'($urandom), tag);
      guard++;
    end
  endtask

  function automatic logic [15:0] sparse_din();
    logic [15:0] v;
    v = 16'($urandom);
    for (int d = 0; d < 4; d++) if ($urandom_range(1, 0) == 1) v[4*d +: 4] = 4'h0;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout k=%0d", k);
    $fatal(1, "bench did not finish");
  end

  initial begin
    bus.LOAD    = 1'b0;
    bus.DIN     = 16'h0;
    bus.DPIN    = 4'h0;
    bus.EN_MASK = 4'hF;
    bus.LZB     = 1'b0;
    k           = 0;
    RST         = 1'b1;
    repeat (2) @(negedge CLK);
    chk4("rst_hold.AN", bus.AN, 4'hF);
    chk4("rst_hold.NIBBLE", bus.NIBBLE, 4'h0);
    chk1("rst_hold.DP", bus.DP, 1'b0);
    chk1("rst_hold.PEND", bus.PEND, 1'b0);
    chk1("rst_hold.FRAME", bus.FRAME, 1'b0);

    @(negedge CLK);
    RST = 1'b0;
    model_reset();

    // Idle scan with zero display.
    idle(70, "idle");

    // Single load mid-frame.
    to_phase(12, "seek");
    cyc(1'b1, 16'h12AF, 4'b0101, "load_12af");
    idle(FRAME_LEN + 8, "show_12af");

    // Two loads in one frame, last wins.
    to_phase(5, "seek");
    cyc(1'b1, 16'h1111, 4'b1111, "load_1111");
    idle(6, "wait");
    cyc(1'b1, 16'h2222, 4'b0010, "load_2222");
    idle(FRAME_LEN + 8, "show_2222");

    // Leading-zero blanking.
    bus.LZB = 1'b1;
    to_phase(4, "seek");
    cyc(1'b1, 16'h0050, 4'b1111, "load_0050");
    idle(2 * FRAME_LEN, "lzb_0050");
    cyc(1'b1, 16'h0000, 4'b1111, "load_0000");
    idle(2 * FRAME_LEN, "lzb_0000");
    bus.EN_MASK = 4'b1011;
    cyc(1'b1, 16'h3000, 4'b1010, "load_3000");
    idle(2 * FRAME_LEN, "mask_3000");
    bus.EN_MASK = 4'hF;
    bus.LZB     = 1'b0;

    // Load coincident with the frame pulse goes straight to the display.
    to_phase(0, "seek");
    cyc(1'b1, 16'hBEEF, 4'b1000, "load_on_frame");
    idle(FRAME_LEN, "show_beef");

    // Pending value overridden by a load on the frame pulse.
    to_phase(20, "seek");
    cyc(1'b1, 16'h7777, 4'b0001, "load_7777");
    to_phase(0, "seek");
    cyc(1'b1, 16'hC0DE, 4'b0100, "load_on_frame2");
    idle(FRAME_LEN, "show_c0de");

    // Randomized traffic.
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(49, 0) == 0) bus.EN_MASK = 4'($urandom);
      if ($urandom_range(79, 0) == 0) bus.LZB = ~bus.LZB;
      if ($urandom_range(15, 0) == 0) cyc(1'b1, sparse_din(), 4'($urandom), "rand_load");
      else                            cyc(1'b0, 16'($urandom), 4'($urandom), "rand");
    end

    // Asynchronous reset while digit 2 is driven and a load is pending.
    bus.EN_MASK = 4'hF;
    bus.LZB     = 1'b0;
    to_phase(0, "seek");
    cyc(1'b1, 16'h5A5A, 4'b0100, "load_5a5a");
    to_phase(10, "seek");
    cyc(1'b1, 16'hA5C3, 4'b1111, "load_a5c3");
    to_phase(20, "seek");
    check_outputs("pre_rst");
    #2 RST = 1'b1;
    #1;
    chk4("async_rst.AN", bus.AN, 4'hF);
    chk4("async_rst.NIBBLE", bus.NIBBLE, 4'h0);
    chk1("async_rst.DP", bus.DP, 1'b0);
    chk1("async_rst.PEND", bus.PEND, 1'b0);
    chk1("async_rst.FRAME", bus.FRAME, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    idle(FRAME_LEN + 12, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
